sobel_edge_engine: RTL and testbench
====================================

Name: sobel_edge_engine

Overview:
Parametrised, pipelined Sobel edge engine producing NUM_WIN adjacent 3x3 gradient magnitudes per accepted beat. Successor to the fixed two-window edge top: adds valid/ready handshakes, a stall-all 3-stage pipeline, saturating magnitude, an output beat counter and an integrated frame-control FSM. Sits between the read-side line buffer and the write-side output packer.

Parameters:
NUM_WIN, 2, number of horizontally adjacent 3x3 windows per beat (>=1)
PIX_W, 8, pixel width in bits
CNT_W, 16, width of out_count

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
data_buffer  in  3*(NUM_WIN+2)*PIX_W  pixel block; pixel(r,c) = bits [(r*(NUM_WIN+2)+c)*PIX_W +: PIX_W], r=0 top row, c=0 leftmost column
in_valid  in  1  data_buffer holds a valid block
in_ready  out  1  engine accepts block this cycle
rd_done  in  1  one-cycle pulse: last input block has been delivered
wr_done  in  1  one-cycle pulse: write side has flushed all results
edge_out  out  NUM_WIN*PIX_W  window k result at bits [k*PIX_W +: PIX_W]
out_valid  out  1  edge_out valid
out_ready  in  1  downstream accepts edge_out
buffer_clear  out  1  one-cycle pulse: line buffer may be cleared
out_count  out  CNT_W  number of output beats accepted this frame
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM=IDLE, all pipeline valid bits 0, edge_out=0, out_valid=0, buffer_clear=0, out_count=0, busy=0.
- Window k uses columns k..k+2. gx = (p02+2p12+p22)-(p00+2p10+p20); gy = (p20+2p21+p22)-(p00+2p01+p02), pRC relative to window.
- Widths: gx,gy signed PIX_W+4 bits; |gx|+|gy| unsigned PIX_W+4 bits (max 8*(2^PIX_W-1), no overflow); result saturates to 2^PIX_W-1.
- Pipeline: S1 registers gx,gy; S2 registers |gx|+|gy|; S3 registers saturated result = edge_out. Latency 3 cycles from accept to out_valid with no stall.
- Advance = !out_valid || out_ready. All stages advance together; no stage updates when Advance=0. Bubbles propagate as valid=0.
- in_ready = Advance && FSM in {IDLE,RUN}. Accept = in_valid && in_ready.
- edge_out and out_valid hold stable while out_valid && !out_ready.
- out_count increments on out_valid && out_ready; wraps at 2^CNT_W; cleared to 0 in CLEAR.
- FSM:
  IDLE: Accept -> RUN (block enters S1).
  RUN: rd_done -> DRAIN (block accepted in same cycle is kept). Accept continues otherwise.
  DRAIN: when all stage valids=0 -> WAIT_WR; in_ready=0.
  WAIT_WR: wr_done -> CLEAR; wr_done arriving earlier (during DRAIN) is latched and honoured.
  CLEAR: buffer_clear=1 for exactly one cycle -> IDLE.
- rd_done in IDLE: -> DRAIN directly (empty frame), yielding buffer_clear after wr_done.
- rd_done/wr_done outside the listed states are ignored; wr_done latch cleared in CLEAR.
- Asynchronous reset mid-frame discards all in-flight data immediately; no buffer_clear is emitted.

Optional Feature:
Macro SOBEL_THRESH_EN. When defined: adds input port thresh (PIX_W) and input bin_mode (1); when bin_mode=1, S3 outputs 2^PIX_W-1 if saturated magnitude >= thresh else 0; thresh and bin_mode sampled at S2->S3 advance. When undefined: no extra ports, S3 always outputs saturated magnitude.

Test Plan:
- Flat block, all pixels 100, NUM_WIN=2, out_ready=1 -> edge_out=0x0000, out_valid exactly 3 cycles after accept.
- Window0 column0=10, other columns 20, all rows -> window0 gx=40,gy=0 -> 40; window1 (cols1..3 all 20) -> 0.
- Column0=0, rest 255 -> window0 magnitude 1020 saturates to 255; window1=0.
- Stream 5 blocks, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during stall, edge_out stable, no beat lost or duplicated, out_count=5.
- 3 blocks then rd_done, wr_done 2 cycles after last out_valid -> states DRAIN, WAIT_WR, one-cycle buffer_clear, IDLE, out_count=0.
- Assert n_rst low with 2 blocks in pipeline -> out_valid=0, busy=0 immediately; after release first new block appears 3 cycles after accept.

Source files
------------

// File: rtl/sobel_edge_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_edge_engine
//  Description : Pipelined 3x3 Sobel edge engine producing NUM_WIN adjacent
//                gradient magnitudes per accepted beat. It has valid/ready
//                handshakes, a 3-stage stall-all pipeline, a saturating
//                magnitude, an output beat counter and frame-control FSM.
//                Optional binarisation is enabled by defining SOBEL_THRESH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_edge_engine #(
    parameter int NUM_WIN = 2,
    parameter int PIX_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [3*(NUM_WIN+2)*PIX_W-1:0]  data_buffer,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            rd_done,
    input  logic                            wr_done,
    output logic [NUM_WIN*PIX_W-1:0]        edge_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            buffer_clear,
    output logic [CNT_W-1:0]                out_count,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0]                thresh,
    input  logic                            bin_mode,
`endif
    output logic                            busy
);

    localparam int c_cols = NUM_WIN + 2;
    localparam int c_gw   = PIX_W + 4;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_run     = 3'd1;
    localparam logic [2:0] c_st_drain   = 3'd2;
    localparam logic [2:0] c_st_wait_wr = 3'd3;
    localparam logic [2:0] c_st_clear   = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    r_wr_seen;
    logic                    r_v1, r_v2, r_v3;
    logic signed [c_gw-1:0]  r_gx [NUM_WIN];
    logic signed [c_gw-1:0]  r_gy [NUM_WIN];
    logic [c_gw-1:0]         r_mag [NUM_WIN];
    logic [NUM_WIN*PIX_W-1:0] r_edge;
    logic [CNT_W-1:0]        r_count;

    logic signed [c_gw-1:0]  w_gx [NUM_WIN];
    logic signed [c_gw-1:0]  w_gy [NUM_WIN];
    logic [c_gw-1:0]         w_abs_sum [NUM_WIN];
    logic [PIX_W-1:0]        w_res [NUM_WIN];
    logic                    w_advance;
    logic                    w_accept;
    logic                    w_take;
    logic                    w_pipe_busy;

    // The whole pipeline moves only when the output slot is free or drained
    assign w_advance   = !r_v3 || out_ready;
    assign in_ready    = w_advance && w_take;
    assign w_accept    = in_valid && in_ready;
    assign w_pipe_busy = r_v1 || r_v2 || r_v3;

    assign edge_out  = r_edge;
    assign out_valid = r_v3;
    assign out_count = r_count;

    for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
        logic signed [c_gw-1:0] w_p [3][3];
        logic [c_gw-1:0]        w_abs_x;
        logic [c_gw-1:0]        w_abs_y;
        logic [PIX_W-1:0]       w_sat;

        // Window k covers columns k..k+2; pixels widened to signed gradient width
        for (genvar r = 0; r < 3; r++) begin : g_row
            for (genvar c = 0; c < 3; c++) begin : g_col
                assign w_p[r][c] = $signed({4'b0000,
                    data_buffer[(r*c_cols + k + c)*PIX_W +: PIX_W]});
            end
        end

        assign w_gx[k] = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
                       - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
        assign w_gy[k] = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
                       - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);

        // |gx|+|gy| never exceeds 8*(2^PIX_W-1), so c_gw bits cannot overflow
        assign w_abs_x      = r_gx[k][c_gw-1] ? -r_gx[k] : r_gx[k];
        assign w_abs_y      = r_gy[k][c_gw-1] ? -r_gy[k] : r_gy[k];
        assign w_abs_sum[k] = w_abs_x + w_abs_y;

        assign w_sat = (|r_mag[k][c_gw-1:PIX_W]) ? {PIX_W{1'b1}}
                                                  : r_mag[k][PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
        assign w_res[k] = bin_mode ? ((w_sat >= thresh) ? {PIX_W{1'b1}} : '0)
                                   : w_sat;
`else
        assign w_res[k] = w_sat;
`endif
    end

    // Three datapath stages advance together; a bubble carries valid=0
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_edge <= '0;
            for (int k = 0; k < NUM_WIN; k++) begin
                r_gx[k]  <= '0;
                r_gy[k]  <= '0;
                r_mag[k] <= '0;
            end
        end else if (w_advance) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            for (int k = 0; k < NUM_WIN; k++) begin
                r_gx[k]  <= w_gx[k];
                r_gy[k]  <= w_gy[k];
                r_mag[k] <= w_abs_sum[k];
                r_edge[k*PIX_W +: PIX_W] <= w_res[k];
            end
        end
    end

    // Output beat counter, restarted for each frame in CLEAR
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (r_state == c_st_clear) begin
            r_count <= '0;
        end else if (r_v3 && out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Frame state register plus latch for a write-flush arriving during DRAIN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= c_st_idle;
            r_wr_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_clear) begin
                r_wr_seen <= 1'b0;
            end else if (r_state == c_st_drain && wr_done) begin
                r_wr_seen <= 1'b1;
            end
        end
    end

    // Frame FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (rd_done) begin
                    w_state_nxt = c_st_drain;
                end else if (w_accept) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (rd_done) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = c_st_wait_wr;
                end
            end
            c_st_wait_wr: begin
                if (wr_done || r_wr_seen) begin
                    w_state_nxt = c_st_clear;
                end
            end
            c_st_clear: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Frame FSM outputs (Moore)
    always_comb begin
        w_take       = (r_state == c_st_idle) || (r_state == c_st_run);
        busy         = (r_state != c_st_idle);
        buffer_clear = (r_state == c_st_clear);
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_edge_engine
//  Description : Directed self-checking bench for sobel_edge_engine
//                (NUM_WIN=2, PIX_W=8, CNT_W=16, SOBEL_THRESH_EN undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_engine;

    localparam int NUM_WIN = 2;
    localparam int PIX_W   = 8;
    localparam int CNT_W   = 16;
    localparam int COLS    = NUM_WIN + 2;

    logic                          clk = 1'b0;
    logic                          n_rst = 1'b0;
    logic [3*COLS*PIX_W-1:0]       data_buffer = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic                          rd_done = 1'b0;
    logic                          wr_done = 1'b0;
    logic [NUM_WIN*PIX_W-1:0]      edge_out;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic                          buffer_clear;
    logic [CNT_W-1:0]              out_count;
    logic                          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    sobel_edge_engine #(
        .NUM_WIN (NUM_WIN),
        .PIX_W   (PIX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_buffer  (data_buffer),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rd_done      (rd_done),
        .wr_done      (wr_done),
        .edge_out     (edge_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .buffer_clear (buffer_clear),
        .out_count    (out_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Every row gets the same four column values
    task automatic set_cols(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] cv [4];
        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                data_buffer[(r*COLS+c)*PIX_W +: PIX_W] = cv[c];
    endtask

    // Every column gets the same three row values
    task automatic set_rows(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2);
        logic [7:0] rv [3];
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                data_buffer[(r*COLS+c)*PIX_W +: PIX_W] = rv[r];
    endtask

    // pixel(r,c) = 10*c + 5*r : gx = 80, gy = 40 in every window
    task automatic set_ramp();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                data_buffer[(r*COLS+c)*PIX_W +: PIX_W] = 8'(10*c + 5*r);
    endtask

    task automatic do_reset();
        n_rst = 1'b0; in_valid = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Offer one block, then wait (bounded) for its result; returns latency
    task automatic send_and_capture(output logic [15:0] res, output int lat,
                                    output bit ok);
        ok = 1'b0; lat = 0; res = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid) begin
                lat = i; res = edge_out; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || edge_out !== 16'h0000 || busy !== 1'b0 ||
            buffer_clear !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: ov=%b eo=%h busy=%b bc=%b cnt=%0d ir=%b, required 0 0000 0 0 0 1",
                     out_valid, edge_out, busy, buffer_clear, out_count, in_ready);
        end
    endtask

    task automatic test_flat();
        logic [15:0] res; int lat; bit ok;
        do_reset();
        set_cols(8'd100, 8'd100, 8'd100, 8'd100);
        send_and_capture(res, lat, ok);
        tests_run++;
        if (!ok || res !== 16'h0000) begin
            tests_failed++;
            $display("FAIL flat_value: got %h (ok=%b), required 0000", res, ok);
        end
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL flat_latency: got %0d, required 3", lat);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] res; int lat; bit ok;
        logic [15:0] exp_v [5];
        string       nm [5];
        exp_v[0] = 16'h0028; nm[0] = "step_col0";
        exp_v[1] = 16'h00FF; nm[1] = "saturate";
        exp_v[2] = 16'hC8C8; nm[2] = "vertical_gy";
        exp_v[3] = 16'h7800; nm[3] = "window1_only";
        exp_v[4] = 16'h7878; nm[4] = "ramp_gx_gy";
        for (int t = 0; t < 5; t++) begin
            do_reset();
            case (t)
                0: set_cols(8'd10, 8'd20, 8'd20, 8'd20);
                1: set_cols(8'd0, 8'd255, 8'd255, 8'd255);
                2: set_rows(8'd0, 8'd0, 8'd50);
                3: set_cols(8'd0, 8'd0, 8'd0, 8'd30);
                default: set_ramp();
            endcase
            send_and_capture(res, lat, ok);
            tests_run++;
            if (!ok || res !== exp_v[t]) begin
                tests_failed++;
                $display("FAIL %s: got %h (ok=%b), required %h", nm[t], res, ok, exp_v[t]);
            end
        end
    endtask

    // Five blocks with out_ready low for cycles 4..7
    task automatic test_back_to_back();
        logic [15:0] exp_q [5];
        int sent = 0;
        int got  = 0;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q[i] = {8'd0, 8'(40*(i+1))};
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (sent < 5);
            if (sent < 5) set_cols(8'd0, 8'(10*(sent+1)), 8'(10*(sent+1)), 8'(10*(sent+1)));
            #1;
            if (!out_ready) begin
                tests_run++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_ready: cyc %0d in_ready=%b out_valid=%b, required 0 1",
                             cyc, in_ready, out_valid);
                end
            end
            if (out_valid) begin
                tests_run++;
                if (edge_out !== exp_q[got]) begin
                    tests_failed++;
                    $display("FAIL stream_beat%0d: cyc %0d got %h, required %h",
                             got, cyc, edge_out, exp_q[got]);
                end
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (got !== 5 || sent !== 5) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d sent %0d, required 5 5", got, sent);
        end
        tests_run++;
        if (out_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL stream_out_count: got %0d, required 5", out_count);
        end
    endtask

    // Three blocks, rd_done, wr_done two cycles after the last beat
    task automatic test_frame();
        int accepted = 0, beats = 0, clears = 0, early = 0;
        int last_ov = -100, rd_cyc = -100;
        bit rd_sent = 0, wr_sent = 0;
        do_reset();
        set_ramp();
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (accepted < 3);
            rd_done  = (accepted == 3) && !rd_sent;
            wr_done  = !wr_sent && (cyc == last_ov + 2);
            #1;
            if (rd_done) begin rd_sent = 1; rd_cyc = cyc; end
            if (cyc == rd_cyc + 1) begin
                tests_run++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL drain_state: busy=%b in_ready=%b, required 1 0", busy, in_ready);
                end
            end
            if (wr_done) begin
                wr_sent = 1;
                tests_run++;
                if (out_count !== 16'd3) begin
                    tests_failed++;
                    $display("FAIL frame_count_pre: got %0d, required 3", out_count);
                end
            end
            if (in_valid && in_ready) accepted++;
            if (out_valid) begin
                beats++;
                if (beats == 3) last_ov = cyc;
            end
            if (buffer_clear) begin
                clears++;
                if (!wr_sent) early++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        tests_run++;
        if (beats !== 3 || clears !== 1 || early !== 0) begin
            tests_failed++;
            $display("FAIL frame_sequence: beats %0d clears %0d early %0d, required 3 1 0",
                     beats, clears, early);
        end
        tests_run++;
        if (busy !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_end: busy=%b cnt=%0d ir=%b, required 0 0 1", busy, out_count, in_ready);
        end
    endtask

    // rd_done straight from IDLE, wr_done arriving while still in DRAIN
    task automatic test_empty_frame();
        int clears = 0;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            rd_done = (cyc == 0);
            wr_done = (cyc == 1);
            #1;
            if (cyc == 1) begin
                tests_run++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL empty_drain: busy=%b in_ready=%b, required 1 0", busy, in_ready);
                end
            end
            if (buffer_clear) clears++;
            @(negedge clk);
        end
        rd_done = 1'b0; wr_done = 1'b0;
        tests_run++;
        if (clears !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_frame: clears %0d busy %b, required 1 0", clears, busy);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] res; int lat; bit ok;
        int stray = 0;
        do_reset();
        set_ramp();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_fill: out_valid=%b busy=%b, required 1 1", out_valid, busy);
        end
        #2 n_rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || edge_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: out_valid=%b busy=%b eo=%h, required 0 0 0000",
                     out_valid, busy, edge_out);
        end
        @(negedge clk);
        n_rst = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid || buffer_clear) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL reset_discard: %0d stray cycles, required 0", stray);
        end
        send_and_capture(res, lat, ok);
        tests_run++;
        if (!ok || lat !== 3 || res !== 16'h7878) begin
            tests_failed++;
            $display("FAIL post_reset_block: got %h lat %0d ok %b, required 7878 3 1", res, lat, ok);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_patterns();
        test_back_to_back();
        test_frame();
        test_empty_frame();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
